shift_seq16: RTL and testbench



---
 rtl/shift_seq16.sv | 138 +++++++++++++
 tb/tb_shift_seq16.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq16.sv
// Multi-cycle 16-bit shifter: one 1-bit shift (or rotate) per clock until the requested amount is reached.
// Latency: done is high after edge `amount` (edge 0 samples start). busy falls one edge later.
// Backpressure: while busy (SHIFT or DONE), start is ignored and not queued. abort cancels SHIFT with no done pulse.
//
// Ports:
//   clk, rst       - clock; asynchronous active-high reset
//   start          - request, sampled only while idle
//   in_16, amount  - operand and shift count (0-15), captured on the accepted start
//   right, arith   - direction (1 = right) and sign-fill on right shifts, captured on the accepted start
//   rotate         - rotate instead of fill; honoured only when SHIFT_SEQ_ROTATE_EN is defined
//   abort          - cancel during SHIFT; out_16 keeps the partial value
//   out_16         - working register; final only while done is high
//   busy, done     - not-idle flag; one-cycle completion pulse
//
// Build option: define SHIFT_SEQ_ROTATE_EN to enable rotate. Otherwise the rotate port is ignored.
module shift_seq16 (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] in_16,
   input  logic [3:0]  amount,
   input  logic        right,
   input  logic        arith,
   input  logic        rotate,
   input  logic        abort,
   output logic [15:0] out_16,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] work;
   logic [3:0]  cnt;
   logic        right_q;
   logic        arith_q;
   logic [15:0] step;
   logic        accept;

   assign accept = (state == S_IDLE) && start;

`ifdef SHIFT_SEQ_ROTATE_EN
   logic rot_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rot_q <= 1'b0;
      end else if (accept) begin
         rot_q <= rotate;
      end
   end
`else
   // The port stays on the block for a uniform interface; nothing consumes it.
   logic rotate_unused;
   assign rotate_unused = rotate;
`endif

   // One step of the shift datapath. Left shifts never sign-fill, so arith only matters for right shifts.
   always_comb begin
      step = {work[14:0], 1'b0};
      if (right_q) begin
         step = {arith_q & work[15], work[15:1]};
      end
`ifdef SHIFT_SEQ_ROTATE_EN
      if (rot_q) begin
         step = right_q ? {work[0], work[15:1]} : {work[14:0], work[15]};
      end
`endif
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. abort wins over the final SHIFT->DONE step.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = (amount == 4'd0) ? S_DONE : S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (abort) begin
               state_nxt = S_IDLE;
            end else if (cnt == 4'd1) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Working register, count and latched controls.
   // An aborted step is not applied, so out_16 keeps the partial value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         work    <= 16'h0000;
         cnt     <= 4'd0;
         right_q <= 1'b0;
         arith_q <= 1'b0;
      end else if (accept) begin
         work    <= in_16;
         cnt     <= amount;
         right_q <= right;
         arith_q <= arith;
      end else if ((state == S_SHIFT) && !abort) begin
         work <= step;
         cnt  <= cnt - 4'd1;
      end
   end

   // Output logic
   always_comb begin
      busy = (state != S_IDLE);
      done = (state == S_DONE);
   end

   assign out_16 = work;

endmodule

// File: tb/tb_shift_seq16.sv
// Self-checking bench for shift_seq16: an operation-level model is compared with the DUT on every negedge,
// and the directed cases also check hand-computed results and latencies.
module tb_shift_seq16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] in_16 = 16'h0000;
   logic [3:0]  amount = 4'd0;
   logic        right = 1'b0;
   logic        arith = 1'b0;
   logic        rotate = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] out_16;
   logic        busy;
   logic        done;

   int tests = 0;
   int fails = 0;

`ifdef SHIFT_SEQ_ROTATE_EN
   localparam bit ROT_EN = 1'b1;
`else
   localparam bit ROT_EN = 1'b0;
`endif

   shift_seq16 dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .in_16  (in_16),
      .amount (amount),
      .right  (right),
      .arith  (arith),
      .rotate (rotate),
      .abort  (abort),
      .out_16 (out_16),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Value of an operand after n single-position steps, computed in closed form.
   function automatic logic [15:0] shifted(input logic [15:0] x, input int n,
                                           input logic r, input logic ar, input logic ro);
      logic [15:0] res;
      if (n == 0) begin
         res = x;
      end else if (ro && ROT_EN) begin
         res = r ? ((x >> n) | (x << (16 - n))) : ((x << n) | (x >> (16 - n)));
      end else if (!r) begin
         res = x << n;
      end else if (ar) begin
         res = $signed(x) >>> n;
      end else begin
         res = x >> n;
      end
      return res;
   endfunction

   // Operation-level model: which operand is loaded, how many steps have been taken, and whether
   // the operation is still running, finishing or finished.
   localparam int P_IDLE  = 0;
   localparam int P_SHIFT = 1;
   localparam int P_DONE  = 2;

   int          m_phase = P_IDLE;
   int          m_steps = 0;
   int          m_amt   = 0;
   logic [15:0] m_in    = 16'h0000;
   logic        m_r = 1'b0, m_ar = 1'b0, m_ro = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = P_IDLE;
         m_steps = 0;
         m_amt   = 0;
         m_in    = 16'h0000;
      end else begin
         case (m_phase)
            P_IDLE: if (start) begin
               m_in    = in_16;
               m_amt   = int'(amount);
               m_r     = right;
               m_ar    = arith;
               m_ro    = rotate;
               m_steps = 0;
               m_phase = (amount == 4'd0) ? P_DONE : P_SHIFT;
            end
            P_SHIFT: if (abort) begin
               m_phase = P_IDLE;
            end else begin
               m_steps++;
               if (m_steps == m_amt) m_phase = P_DONE;
            end
            default: m_phase = P_IDLE;
         endcase
      end
   end

   always @(negedge clk) begin
      check("busy", 32'(busy), 32'(m_phase != P_IDLE));
      check("done", 32'(done), 32'(m_phase == P_DONE));
      check("out_16", 32'(out_16), 32'(shifted(m_in, m_steps, m_r, m_ar, m_ro)));
   end

   // Starts an operation (called at posedge+1 while idle) and returns after edge 0, at posedge+1.
   task automatic launch(input logic [15:0] d, input logic [3:0] a,
                         input logic r, input logic ar, input logic ro);
      in_16 = d; amount = a; right = r; arith = ar; rotate = ro; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Waits (bounded) for done, then checks the latency, the final value and the busy drop one edge later.
   task automatic finish_op(input string name, input int edges_done, input int exp_lat, input logic [15:0] exp);
      int n;
      n = edges_done;
      while (!done && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_latency"}, 32'(n), 32'(exp_lat));
      check({name, "_result"}, 32'(out_16), 32'(exp));
      @(posedge clk); #1;
      start = 1'b0;
      check({name, "_idle_after"}, 32'({busy, done}), 32'h0);
   endtask

   task automatic run_op(input string name, input logic [15:0] d, input logic [3:0] a,
                         input logic r, input logic ar, input logic ro,
                         input int exp_lat, input logic [15:0] exp);
      launch(d, a, r, ar, ro);
      finish_op(name, 0, exp_lat, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", 32'({out_16, busy, done}), 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op("lsr_8001_4", 16'h8001, 4'd4, 1'b1, 1'b0, 1'b0, 4, 16'h0800);
      run_op("asr_8000_15", 16'h8000, 4'd15, 1'b1, 1'b1, 1'b0, 15, 16'hFFFF);
      run_op("asr_4000_15", 16'h4000, 4'd15, 1'b1, 1'b1, 1'b0, 15, 16'h0000);
      run_op("lsl_0001_15", 16'h0001, 4'd15, 1'b0, 1'b0, 1'b0, 15, 16'h8000);
      run_op("lsl_arith_ignored", 16'hC001, 4'd1, 1'b0, 1'b1, 1'b0, 1, 16'h8002);
      run_op("zero_amount", 16'h1234, 4'd0, 1'b0, 1'b0, 1'b0, 0, 16'h1234);

      // start held high from SHIFT through the DONE cycle must be ignored
      launch(16'h00F0, 4'd3, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      in_16 = 16'hFFFF; amount = 4'd0; start = 1'b1;
      finish_op("start_while_busy", 1, 3, 16'h0780);

      // abort in IDLE alongside start does not block acceptance
      abort = 1'b1;
      launch(16'h0003, 4'd1, 1'b1, 1'b0, 1'b0);
      abort = 1'b0;
      finish_op("abort_in_idle", 0, 1, 16'h0001);

      // abort after edge 2 of an 8-step shift: partial value kept, no done
      launch(16'h00FF, 4'd8, 1'b0, 1'b0, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_mid_state", 32'({busy, done}), 32'h0);
      check("abort_mid_value", 32'(out_16), 32'h03FC);
      repeat (3) begin @(posedge clk); #1; end
      check("abort_mid_no_done", 32'({busy, done}), 32'h0);

      // abort on the last SHIFT cycle wins over the move to DONE
      launch(16'h0001, 4'd2, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_last_state", 32'({busy, done}), 32'h0);
      check("abort_last_value", 32'(out_16), 32'h0002);

      // reset in the middle of SHIFT clears everything at once; the next op runs normally
      launch(16'hABCD, 4'd10, 1'b0, 1'b0, 1'b0);
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      check("reset_mid_op", 32'({out_16, busy, done}), 32'h0);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run_op("after_reset", 16'h0F00, 4'd4, 1'b1, 1'b0, 1'b0, 4, 16'h00F0);

      // rotate request: honoured only when the option is built in
      run_op("rotate_right_1", 16'h0001, 4'd1, 1'b1, 1'b0, 1'b1, 1, ROT_EN ? 16'h8000 : 16'h0000);
      run_op("rotate_left_4", 16'h8421, 4'd4, 1'b0, 1'b1, 1'b1, 4, ROT_EN ? 16'h4218 : 16'h4210);

      repeat (3) @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
